// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared widths and FSM state types for the parking gate controller
package parking_pkg;

    localparam int SLOT_W = 3;
    localparam int CODE_W = 8;

    typedef enum logic [1:0] {
        E_IDLE,
        E_REQ,
        E_OPEN,
        E_FULL
    } entry_state_t;

    typedef enum logic [2:0] {
        X_IDLE,
        X_REQ,
        X_OPEN,
        X_DENY,
        X_LOCK
    } exit_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gate_barrier_timer.sv
// rtl/gate_barrier_timer.sv - holds a barrier open until its beam clears or TIMEOUT cycles pass
module gate_barrier_timer #(
    parameter int TIMEOUT = 32,
    parameter int TW      = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear_beam,
    output logic gate_open,
    output logic done
);

    localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] cnt;

    // done marks the final open cycle; the gate drops at the following edge
    assign done = gate_open && (clear_beam || (cnt == LAST));

    always_ff @(posedge clk) begin
        if (rst) begin
            gate_open <= 1'b0;
            cnt       <= '0;
        end else if (start) begin
            gate_open <= 1'b1;
            cnt       <= '0;
        end else if (gate_open) begin
            if (done) begin
                gate_open <= 1'b0;
            end else begin
                cnt <= cnt + TW'(1);
            end
        end
    end

endmodule

// File: rtl/parking_gate_ctrl.sv
// rtl/parking_gate_ctrl.sv - entry/exit barrier controller driving the slot allocate/release handshakes
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int TIMEOUT     = 32,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              entry_sensor,
    input  logic              entry_clear,
    input  logic              exit_sensor,
    input  logic              exit_present,
    input  logic [SLOT_W-1:0] exit_slot,
    input  logic [CODE_W-1:0] exit_code,
    input  logic              exit_clear,
    output logic              alloc_req,
    input  logic              alloc_ack,
    input  logic              alloc_ok,
    input  logic [SLOT_W-1:0] alloc_slot,
    input  logic [CODE_W-1:0] alloc_code,
    output logic              rel_req,
    output logic [SLOT_W-1:0] rel_slot,
    output logic [CODE_W-1:0] rel_code,
    input  logic              rel_ack,
    input  logic              rel_ok,
    output logic              entry_gate_open,
    output logic              exit_gate_open,
    output logic              ticket_valid,
    output logic [SLOT_W-1:0] ticket_slot,
    output logic [CODE_W-1:0] ticket_code,
    output logic              full_flag,
    output logic              deny,
    output logic              alarm
);

    localparam int TW = $clog2(max2(TIMEOUT, LOCK_CYCLES) + 1);
    localparam int CW = $clog2(MAX_TRIES + 1);

    localparam logic [CW-1:0] TRIES_MAX = CW'(MAX_TRIES);
    localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_CYCLES - 1);

    entry_state_t e_state, e_next;
    exit_state_t  x_state, x_next;

    logic          e_grant, e_refuse, e_done, e_deny_q;
    logic          x_accept, x_match, x_miss, x_done, lock_last;
    logic [CW-1:0] tries, tries_inc;
    logic [TW-1:0] lock_cnt;

    // acks only count while the matching request is up
    assign e_grant   = (e_state == E_REQ) && alloc_ack && alloc_ok;
    assign e_refuse  = (e_state == E_REQ) && alloc_ack && !alloc_ok;
    assign x_accept  = (x_state == X_IDLE) && exit_present && exit_sensor;
    assign x_match   = (x_state == X_REQ) && rel_ack && rel_ok;
    assign x_miss    = (x_state == X_REQ) && rel_ack && !rel_ok;
    assign tries_inc = (tries == TRIES_MAX) ? tries : tries + CW'(1);
    assign lock_last = (lock_cnt == LOCK_LAST);

    assign alloc_req = (e_state == E_REQ);
    assign rel_req   = (x_state == X_REQ);
    assign alarm     = (x_state == X_LOCK);
    assign deny      = e_deny_q || (x_state == X_DENY);

    gate_barrier_timer #(.TIMEOUT(TIMEOUT), .TW(TW)) u_entry_timer (
        .clk        (clk),
        .rst        (rst),
        .start      (e_grant),
        .clear_beam (entry_clear),
        .gate_open  (entry_gate_open),
        .done       (e_done)
    );

    gate_barrier_timer #(.TIMEOUT(TIMEOUT), .TW(TW)) u_exit_timer (
        .clk        (clk),
        .rst        (rst),
        .start      (x_match),
        .clear_beam (exit_clear),
        .gate_open  (exit_gate_open),
        .done       (x_done)
    );

    always_comb begin
        e_next = e_state;
        case (e_state)
            E_IDLE:  if (entry_sensor) e_next = E_REQ;
            E_REQ:   if (alloc_ack) e_next = alloc_ok ? E_OPEN : E_FULL;
            E_OPEN:  if (e_done) e_next = E_IDLE;
            E_FULL:  if (!entry_sensor) e_next = E_IDLE;
            default: e_next = E_IDLE;
        endcase
    end

    always_comb begin
        x_next = x_state;
        case (x_state)
            X_IDLE: if (x_accept) x_next = X_REQ;
            X_REQ: begin
                if (x_match) begin
                    x_next = X_OPEN;
                end else if (x_miss) begin
                    x_next = (tries_inc == TRIES_MAX) ? X_LOCK : X_DENY;
                end
            end
            X_DENY:  x_next = X_IDLE;
            X_OPEN:  if (x_done) x_next = X_IDLE;
            X_LOCK:  if (lock_last) x_next = X_IDLE;
            default: x_next = X_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            e_state      <= E_IDLE;
            x_state      <= X_IDLE;
            ticket_valid <= 1'b0;
            ticket_slot  <= '0;
            ticket_code  <= '0;
            e_deny_q     <= 1'b0;
            full_flag    <= 1'b0;
            rel_slot     <= '0;
            rel_code     <= '0;
            tries        <= '0;
            lock_cnt     <= '0;
        end else begin
            e_state      <= e_next;
            x_state      <= x_next;
            ticket_valid <= e_grant;
            e_deny_q     <= e_refuse;
            if (e_grant) begin
                ticket_slot <= alloc_slot;
                ticket_code <= alloc_code;
            end
            // a release landing with a refusal wins: the lot has a free slot again
            if (x_match || e_grant) begin
                full_flag <= 1'b0;
            end else if (e_refuse) begin
                full_flag <= 1'b1;
            end
            if (x_accept) begin
                rel_slot <= exit_slot;
                rel_code <= exit_code;
            end
            if ((x_state == X_IDLE) && !exit_sensor) begin
                tries <= '0;
            end else if (x_match) begin
                tries <= '0;
            end else if (x_miss) begin
                tries <= tries_inc;
            end else if ((x_state == X_LOCK) && lock_last) begin
                tries <= '0;
            end
            if (x_state != X_LOCK) begin
                lock_cnt <= '0;
            end else if (!lock_last) begin
                lock_cnt <= lock_cnt + TW'(1);
            end
        end
    end

endmodule
